change_dispenser: RTL and testbench

Pays out the customer's remaining balance as physical coins, one coin at a time, through a four-phase request/acknowledge handshake with the coin hopper. The coin-counting input path accepts 1/5/10 coins and produces a 5-bit balance; this block drives the opposite direction of the same coin interface. It sits after the balance-minus-price subtraction and is started by the purchase-confirm logic. Its `remaining` output feeds the 5→4+4 display decoder.

---
 rtl/vend_pkg.sv | 38 +++
 rtl/coin_select.sv | 28 ++
 rtl/change_dispenser.sv | 112 +++++++++++
 tb/tb_change_dispenser.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change path.
// Denomination and payout-FSM encodings used by the dispenser.
package vend_pkg;

    localparam int DEF_BAL_W = 5;

    localparam int COIN1  = 1;
    localparam int COIN5  = 5;
    localparam int COIN10 = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        REQ     = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4,
        FAULT   = 3'd5
    } chg_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        D1   = 2'd1,
        D5   = 2'd2,
        D10  = 2'd3
    } denom_t;

    function automatic int denom_value(denom_t d);
        int v;
        unique case (d)
            D10:     v = COIN10;
            D5:      v = COIN5;
            D1:      v = COIN1;
            default: v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy denomination picker: largest coin that fits the balance
// and whose hopper tube still has coins.
module coin_select
    import vend_pkg::*;
#(
    parameter int BAL_W = DEF_BAL_W
) (
    input  logic [BAL_W-1:0] remaining,
    input  logic             empty10,
    input  logic             empty5,
    input  logic             empty1,
    output denom_t           denom,
    output logic [BAL_W-1:0] value
);

    always_comb begin
        denom = NONE;
        if (remaining >= BAL_W'(COIN10) && !empty10) begin
            denom = D10;
        end else if (remaining >= BAL_W'(COIN5) && !empty5) begin
            denom = D5;
        end else if (remaining >= BAL_W'(COIN1) && !empty1) begin
            denom = D1;
        end
        value = BAL_W'(denom_value(denom));
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a balance one coin at a time over a four-phase
// request/ack handshake with the coin hopper.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int BAL_W       = DEF_BAL_W,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BAL_W-1:0] amount,
    input  logic             empty10,
    input  logic             empty5,
    input  logic             empty1,
    input  logic             hopper_ack,
    output logic             coin10,
    output logic             coin5,
    output logic             coin1,
    output logic [BAL_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    chg_state_t       state;
    denom_t           denom_q;
    logic [BAL_W-1:0] val_q;
    logic [BAL_W-1:0] rem_q;
    logic [CNT_W-1:0] cnt;

    denom_t           pick;
    logic [BAL_W-1:0] pick_value;
    logic             expired;

    coin_select #(.BAL_W(BAL_W)) u_sel (
        .remaining (rem_q),
        .empty10   (empty10),
        .empty5    (empty5),
        .empty1    (empty1),
        .denom     (pick),
        .value     (pick_value)
    );

    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            denom_q <= NONE;
            val_q   <= '0;
            rem_q   <= '0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE, FAULT: begin
                    if (start) begin
                        rem_q <= amount;
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    cnt <= '0;
                    if (rem_q == '0) begin
                        state <= DONE;
                    end else if (pick == NONE) begin
                        state <= FAULT;
                    end else if (!hopper_ack) begin
                        // a stale ack must clear before a new request
                        denom_q <= pick;
                        val_q   <= pick_value;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (hopper_ack) begin
                        rem_q <= rem_q - val_q;
                        cnt   <= '0;
                        state <= RELEASE;
                    end else if (expired) begin
                        state <= FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!hopper_ack) begin
                        state <= SELECT;
                    end else if (expired) begin
                        state <= FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign coin10    = (state == REQ) && (denom_q == D10);
    assign coin5     = (state == REQ) && (denom_q == D5);
    assign coin1     = (state == REQ) && (denom_q == D1);
    assign remaining = rem_q;
    assign busy      = (state == SELECT) || (state == REQ) || (state == RELEASE);
    assign done      = (state == DONE);
    assign fault     = (state == FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench: expected coin sequence queued per payout,
// popped as the dispenser raises each request.
module tb_change_dispenser;

    localparam int TMO = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] amount = '0;
    logic       empty10 = 1'b0;
    logic       empty5 = 1'b0;
    logic       empty1 = 1'b0;
    logic       hopper_ack = 1'b0;
    logic       coin10, coin5, coin1;
    logic [4:0] remaining;
    logic       busy, done, fault;

    int passed = 0;
    int total = 0;
    int exp_q[$];

    change_dispenser #(.BAL_W(5), .ACK_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .empty10    (empty10),
        .empty5     (empty5),
        .empty1     (empty1),
        .hopper_ack (hopper_ack),
        .coin10     (coin10),
        .coin5      (coin5),
        .coin1      (coin1),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({coin10, coin5, coin1, busy, done, fault} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000",
                     {coin10, coin5, coin1, busy, done, fault});
        else passed++;
        total++;
        if (remaining !== 5'd0)
            $display("FAIL reset_rem: got %0d want 0", remaining);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_payout(input string name, input logic [4:0] amt,
                              input logic pulse_busy);
        int guard;
        int got;
        int want;
        int rem;
        @(negedge clk);
        amount = amt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || fault !== 1'b0 || remaining !== amt)
            $display("FAIL %s_start: busy=%b fault=%b rem=%0d want 1 0 %0d",
                     name, busy, fault, remaining, amt);
        else passed++;
        rem = amt;
        guard = 0;
        while (!done && guard < 200) begin
            if (coin10 | coin5 | coin1) begin
                got = coin10 ? 10 : coin5 ? 5 : 1;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                total++;
                if ($countones({coin10, coin5, coin1}) != 1 || got != want)
                    $display("FAIL %s_coin: got %0d (%b) want %0d",
                             name, got, {coin10, coin5, coin1}, want);
                else passed++;
                total++;
                if (remaining !== 5'(rem))
                    $display("FAIL %s_rem_before: got %0d want %0d",
                             name, remaining, rem);
                else passed++;
                if (pulse_busy) begin
                    amount = 5'd31;
                    start = 1'b1;
                end
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                total++;
                if ((coin10 | coin5 | coin1) !== 1'b1)
                    $display("FAIL %s_hold: got %b want one coin held",
                             name, {coin10, coin5, coin1});
                else passed++;
                hopper_ack = 1'b1;
                @(negedge clk);
                rem = rem - want;
                total++;
                if ({coin10, coin5, coin1} !== 3'b0 || remaining !== 5'(rem))
                    $display("FAIL %s_ack: coins=%b rem=%0d want 000 %0d",
                             name, {coin10, coin5, coin1}, remaining, rem);
                else passed++;
                hopper_ack = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 200 || exp_q.size() != 0)
            $display("FAIL %s_end: guard=%0d left=%0d want done, queue empty",
                     name, guard, exp_q.size());
        else passed++;
        exp_q.delete();
        total++;
        if (remaining !== 5'd0 || fault !== 1'b0)
            $display("FAIL %s_final: rem=%0d fault=%b want 0 0",
                     name, remaining, fault);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_pulse: done=%b busy=%b want 0 0",
                     name, done, busy);
        else passed++;
    endtask

    task automatic test_greedy();
        exp_q = '{10, 5, 1, 1};
        run_payout("greedy17", 5'd17, 1'b1);
    endtask

    task automatic test_empty10();
        empty10 = 1'b1;
        exp_q = '{5, 5, 5, 1, 1};
        run_payout("empty10", 5'd17, 1'b0);
        empty10 = 1'b0;
    endtask

    task automatic test_zero();
        @(negedge clk);
        amount = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL zero_edge1: done=%b busy=%b want 0 1", done, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b1 || {coin10, coin5, coin1} !== 3'b0)
            $display("FAIL zero_edge2: done=%b coins=%b want 1 000",
                     done, {coin10, coin5, coin1});
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL zero_after: done=%b busy=%b want 0 0", done, busy);
        else passed++;
    endtask

    task automatic test_timeout();
        int held;
        @(negedge clk);
        amount = 5'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        held = 0;
        while (coin5 === 1'b1 && held < 400) begin
            held++;
            @(negedge clk);
        end
        total++;
        if (held != TMO)
            $display("FAIL tmo_held: got %0d cycles want %0d", held, TMO);
        else passed++;
        total++;
        if (fault !== 1'b1 || remaining !== 5'd8 ||
            {coin10, coin5, coin1} !== 3'b0 || busy !== 1'b0)
            $display("FAIL tmo_state: fault=%b rem=%0d coins=%b busy=%b want 1 8 000 0",
                     fault, remaining, {coin10, coin5, coin1}, busy);
        else passed++;
        exp_q = '{1, 1, 1};
        run_payout("restart3", 5'd3, 1'b0);
    endtask

    task automatic test_undispensable();
        empty1 = 1'b1;
        @(negedge clk);
        amount = 5'd4;
        start = 1'b1;
        @(negedge clk);
        amount = 5'd9;
        total++;
        if (busy !== 1'b1)
            $display("FAIL undisp_busy: got %b want 1", busy);
        else passed++;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (fault !== 1'b1 || remaining !== 5'd4 || busy !== 1'b0 ||
            {coin10, coin5, coin1} !== 3'b0)
            $display("FAIL undisp_fault: fault=%b rem=%0d busy=%b coins=%b want 1 4 0 000",
                     fault, remaining, busy, {coin10, coin5, coin1});
        else passed++;
        empty1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard;
        @(negedge clk);
        amount = 5'd23;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (coin10 !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        total++;
        if (coin10 !== 1'b1 || remaining !== 5'd23)
            $display("FAIL rst_pre: coin10=%b rem=%0d want 1 23",
                     coin10, remaining);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({coin10, coin5, coin1, busy, done, fault} !== 6'b0 ||
            remaining !== 5'd0)
            $display("FAIL rst_async: flags=%b rem=%0d want 000000 0",
                     {coin10, coin5, coin1, busy, done, fault}, remaining);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || remaining !== 5'd0)
            $display("FAIL rst_idle: busy=%b rem=%0d want 0 0", busy, remaining);
        else passed++;
        exp_q = '{5, 1};
        run_payout("after_rst", 5'd6, 1'b0);
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_empty10();
        test_zero();
        test_timeout();
        test_undispensable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
